regfile_scoreboard: RTL and testbench

//  Parametrised 2-read/1-write register file with a per-register busy scoreboard for the pipelined core.

---
 rtl/regfile_scoreboard.sv | 142 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with a per-register busy scoreboard and pending-reservation counter.
// Optional same-cycle write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.

module regfile_scoreboard_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int DEPTH = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]             rd_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs_i,
    input  logic [DEPTH-1:0]              busy_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          rd_busy_o
);
    logic addr_zero;
    assign addr_zero = (rd_addr_i == '0);

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;
    // A reserve in the same cycle lands after the edge, so the forwarded read still sees busy=0.
    assign fwd_hit = wr_en_i && !addr_zero && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (fwd_hit) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end else if (!addr_zero) begin
            rd_data_o = regs_i[rd_addr_i];
            rd_busy_o = busy_i[rd_addr_i];
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (!addr_zero) begin
            rd_data_o = regs_i[rd_addr_i];
            rd_busy_o = busy_i[rd_addr_i];
        end
    end
`endif
endmodule

module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    output logic              rd1_busy_o,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    output logic [DATA_W-1:0] rd2_data_o,
    output logic              rd2_busy_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic              stall_o,
    output logic [CNT_W-1:0]  pending_cnt_o
);
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int NUM_RD   = 2;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic wr_ok, rsv_ok, set_evt, clr_evt;

    assign wr_ok  = wr_en_i  && (wr_addr_i  != '0);
    assign rsv_ok = rsv_en_i && (rsv_addr_i != '0);

    // Counter tracks busy transitions only; a write+reserve on one busy register nets to no change.
    assign set_evt = rsv_ok && !busy_q[rsv_addr_i];
    assign clr_evt = wr_ok && busy_q[wr_addr_i] && !(rsv_ok && (rsv_addr_i == wr_addr_i));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr_i] = wr_data_i;
            busy_d[wr_addr_i] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(set_evt) - CNT_W'(clr_evt);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;

    assign rd_addr = {rd2_addr_i, rd1_addr_i};

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_scoreboard_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .rd_addr_i (rd_addr[g]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .rd_data_o (rd_data[g]),
            .rd_busy_o (rd_busy[g])
        );
    end

    assign rd1_data_o    = rd_data[0];
    assign rd1_busy_o    = rd_busy[0];
    assign rd2_data_o    = rd_data[1];
    assign rd2_busy_o    = rd_busy[1];
    assign stall_o       = |rd_busy;
    assign pending_cnt_o = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, r0 immunity, reserve/release, collisions,
// forwarding (either build) and asynchronous reset while the scoreboard is full.

module tb_regfile_scoreboard;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [4:0]  rd1_addr_i, rd2_addr_i, wr_addr_i, rsv_addr_i;
    logic [31:0] rd1_data_o, rd2_data_o, wr_data_i;
    logic        rd1_busy_o, rd2_busy_o, wr_en_i, rsv_en_i, stall_o;
    logic [5:0]  pending_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    regfile_scoreboard dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .rd1_addr_i    (rd1_addr_i),
        .rd1_data_o    (rd1_data_o),
        .rd1_busy_o    (rd1_busy_o),
        .rd2_addr_i    (rd2_addr_i),
        .rd2_data_o    (rd2_data_o),
        .rd2_busy_o    (rd2_busy_o),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .rsv_en_i      (rsv_en_i),
        .rsv_addr_i    (rsv_addr_i),
        .stall_o       (stall_o),
        .pending_cnt_o (pending_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i  = 1'b0;
        rsv_en_i = 1'b0;
    endtask

    initial begin
        rst_n_i    = 1'b0;
        rd1_addr_i = '0;
        rd2_addr_i = '0;
        wr_addr_i  = '0;
        rsv_addr_i = '0;
        wr_data_i  = '0;
        wr_en_i    = 1'b0;
        rsv_en_i   = 1'b0;
        #2;
        chk("rst_cnt_during", 32'(pending_cnt_o), 32'd0);
        step();
        step();
        rst_n_i = 1'b1;
        #1;

        // 1: every register reads zero and idle after reset
        for (int a = 0; a < 32; a++) begin
            rd1_addr_i = 5'(a);
            rd2_addr_i = 5'(31 - a);
            #1;
            chk("rst_rd1_data", rd1_data_o, 32'd0);
            chk("rst_rd2_data", rd2_data_o, 32'd0);
            chk("rst_busy", {30'd0, rd1_busy_o, rd2_busy_o}, 32'd0);
        end
        chk("rst_cnt", 32'(pending_cnt_o), 32'd0);

        wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'hFFFF_FFFF;
        rsv_en_i = 1'b1; rsv_addr_i = 5'd0;
        step();
        idle();
        rd1_addr_i = 5'd0;
        #1;
        chk("r0_data", rd1_data_o, 32'd0);
        chk("r0_busy", 32'(rd1_busy_o), 32'd0);
        chk("r0_cnt", 32'(pending_cnt_o), 32'd0);

        // 2: reserve then release r5
        rsv_en_i = 1'b1; rsv_addr_i = 5'd5;
        step();
        idle();
        rd1_addr_i = 5'd5;
        rd2_addr_i = 5'd6;
        #1;
        chk("r5_busy", 32'(rd1_busy_o), 32'd1);
        chk("r5_stall", 32'(stall_o), 32'd1);
        chk("r5_cnt", 32'(pending_cnt_o), 32'd1);
        chk("r6_busy", 32'(rd2_busy_o), 32'd0);
        wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'h1234;
        step();
        idle();
        #1;
        chk("r5_data", rd1_data_o, 32'h1234);
        chk("r5_rel_busy", 32'(rd1_busy_o), 32'd0);
        chk("r5_rel_cnt", 32'(pending_cnt_o), 32'd0);
        chk("r5_rel_stall", 32'(stall_o), 32'd0);

        // 3: write+reserve same register, busy before (net 0) and not busy before (+1)
        rsv_en_i = 1'b1; rsv_addr_i = 5'd7;
        step();
        chk("r7_pre_cnt", 32'(pending_cnt_o), 32'd1);
        wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'hA5;
        step();
        idle();
        rd1_addr_i = 5'd7;
        #1;
        chk("r7_data", rd1_data_o, 32'hA5);
        chk("r7_busy", 32'(rd1_busy_o), 32'd1);
        chk("r7_cnt", 32'(pending_cnt_o), 32'd1);

        wr_en_i = 1'b1; wr_addr_i = 5'd8; wr_data_i = 32'h88;
        rsv_en_i = 1'b1; rsv_addr_i = 5'd8;
        step();
        wr_addr_i = 5'd9; wr_data_i = 32'h99;
        rsv_addr_i = 5'd7;
        rd1_addr_i = 5'd8;
        #1;
        chk("r8_data", rd1_data_o, 32'h88);
        chk("r8_busy", 32'(rd1_busy_o), 32'd1);
        chk("r8_cnt", 32'(pending_cnt_o), 32'd2);
        step();
        idle();
        rd1_addr_i = 5'd9;
        rd2_addr_i = 5'd7;
        #1;
        chk("r9_data", rd1_data_o, 32'h99);
        chk("r9_busy", 32'(rd1_busy_o), 32'd0);
        chk("r7_rersv_busy", 32'(rd2_busy_o), 32'd1);
        chk("nonbusy_wr_cnt", 32'(pending_cnt_o), 32'd2);

        // 4: same-cycle write to a busy register being read
        rsv_en_i = 1'b1; rsv_addr_i = 5'd3;
        step();
        idle();
        chk("r3_rsv_cnt", 32'(pending_cnt_o), 32'd3);
        rd2_addr_i = 5'd3;
        wr_en_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'hDEAD;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rd2_data_o, 32'hDEAD);
        chk("byp_busy", 32'(rd2_busy_o), 32'd0);
`else
        chk("nobyp_data", rd2_data_o, 32'd0);
        chk("nobyp_busy", 32'(rd2_busy_o), 32'd1);
`endif
        step();
        idle();
        #1;
        chk("r3_data", rd2_data_o, 32'hDEAD);
        chk("r3_busy", 32'(rd2_busy_o), 32'd0);
        chk("r3_cnt", 32'(pending_cnt_o), 32'd2);

        // 5: fill the scoreboard, then async reset mid-sequence
        for (int a = 1; a < 32; a++) begin
            rsv_en_i = 1'b1; rsv_addr_i = 5'(a);
            step();
        end
        idle();
        #1;
        chk("full_cnt", 32'(pending_cnt_o), 32'd31);
        rd1_addr_i = 5'd31;
        rd2_addr_i = 5'd1;
        #1;
        chk("full_busy", {30'd0, rd1_busy_o, rd2_busy_o}, 32'd3);

        for (int a = 1; a < 5; a++) begin
            wr_en_i = 1'b1; wr_addr_i = 5'(a); wr_data_i = 32'(a * 16);
            step();
        end
        idle();
        chk("drain_cnt", 32'(pending_cnt_o), 32'd27);

        rd1_addr_i = 5'd7;
        rd2_addr_i = 5'd2;
        rsv_en_i = 1'b1; rsv_addr_i = 5'd1;
        step();
        rsv_addr_i = 5'd2;
        step();
        chk("pre_rst_cnt", 32'(pending_cnt_o), 32'd29);
        rsv_addr_i = 5'd3;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_cnt", 32'(pending_cnt_o), 32'd0);
        chk("async_busy", {30'd0, rd1_busy_o, rd2_busy_o}, 32'd0);
        chk("async_stall", 32'(stall_o), 32'd0);
        chk("async_r7_data", rd1_data_o, 32'd0);
        chk("async_r2_data", rd2_data_o, 32'd0);
        idle();
        step();
        rst_n_i = 1'b1;
        step();
        chk("post_rst_cnt", 32'(pending_cnt_o), 32'd0);
        chk("post_rst_busy", 32'(stall_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
